// File: rtl/comparador_bcd_serial_pkg.sv
// Shared definitions for the serial BCD comparator: state encoding, digit
// geometry and the result-flag bundle.
package comparador_bcd_serial_pkg;

   localparam int          BCD_W   = 4;
   localparam logic [3:0]  BCD_MAX = 4'd9;

   localparam logic [1:0]  ST_IDLE = 2'd0;
   localparam logic [1:0]  ST_CMP  = 2'd1;
   localparam logic [1:0]  ST_FIM  = 2'd2;

   typedef struct packed {
      logic gt;
      logic lt;
      logic eq;
      logic err;
   } flags_t;

   localparam flags_t FLAGS_CLR = '{gt: 1'b0, lt: 1'b0, eq: 1'b0, err: 1'b0};

   function automatic logic digito_valido(input logic [BCD_W-1:0] dig);
      return dig <= BCD_MAX;
   endfunction

endpackage

// File: rtl/comparador_bcd_serial_digito.sv
// Combinational compare of one BCD digit pair; ordering outputs are masked
// whenever either digit is not a legal BCD value.
module comparador_digito_bcd
   import comparador_bcd_serial_pkg::*;
(
   input  logic [BCD_W-1:0] i_dig_a,
   input  logic [BCD_W-1:0] i_dig_b,
   output logic             o_maior,
   output logic             o_menor,
   output logic             o_igual,
   output logic             o_invalido
);

   logic w_invalido;

   assign w_invalido = !digito_valido(i_dig_a) || !digito_valido(i_dig_b);

   assign o_invalido = w_invalido;
   assign o_maior    = !w_invalido && (i_dig_a > i_dig_b);
   assign o_menor    = !w_invalido && (i_dig_a < i_dig_b);
   assign o_igual    = !w_invalido && (i_dig_a == i_dig_b);

endmodule

// File: rtl/comparador_bcd_serial.sv
// Serial packed-BCD magnitude comparator, one digit pair per cycle, most
// significant digit first, with early exit on the first difference or bad digit.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for start; result flags hold the last outcome
// CMP     | comparing latched digit pair at r_idx
// FIM     | one-cycle done pulse, result flags valid
module comparador_bcd_serial
   import comparador_bcd_serial_pkg::*;
#(
   parameter int NDIG = 4
)
(
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_start,
   input  logic [4*NDIG-1:0]     i_a,
   input  logic [4*NDIG-1:0]     i_b,
   output logic                  o_busy,
   output logic                  o_done,
   output logic                  o_gt,
   output logic                  o_lt,
   output logic                  o_eq,
   output logic                  o_err
);

   localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam logic [IDX_W-1:0] IDX_MSD = IDX_W'(NDIG - 1);

   logic [1:0]          r_state;
   logic [IDX_W-1:0]    r_idx;
   logic [4*NDIG-1:0]   r_a;
   logic [4*NDIG-1:0]   r_b;
   flags_t              r_flags;

   logic [BCD_W-1:0]    w_dig_a;
   logic [BCD_W-1:0]    w_dig_b;
   logic                w_maior;
   logic                w_menor;
   logic                w_igual;
   logic                w_invalido;

   // Index multiplexer feeding the single shared digit comparator.
   always_comb begin
      w_dig_a = '0;
      w_dig_b = '0;
      for (int i = 0; i < NDIG; i++) begin
         if (r_idx == IDX_W'(i)) begin
            w_dig_a = r_a[i*BCD_W +: BCD_W];
            w_dig_b = r_b[i*BCD_W +: BCD_W];
         end
      end
   end

   comparador_digito_bcd u_digito (
      .i_dig_a    (w_dig_a),
      .i_dig_b    (w_dig_b),
      .o_maior    (w_maior),
      .o_menor    (w_menor),
      .o_igual    (w_igual),
      .o_invalido (w_invalido)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= ST_IDLE;
         r_idx   <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_flags <= FLAGS_CLR;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (i_start) begin
                  r_a     <= i_a;
                  r_b     <= i_b;
                  r_idx   <= IDX_MSD;
                  r_flags <= FLAGS_CLR;
                  r_state <= ST_CMP;
               end
            end
            ST_CMP: begin
               if (w_invalido) begin
                  r_flags.err <= 1'b1;
                  r_state     <= ST_FIM;
               end else if (w_maior) begin
                  r_flags.gt  <= 1'b1;
                  r_state     <= ST_FIM;
               end else if (w_menor) begin
                  r_flags.lt  <= 1'b1;
                  r_state     <= ST_FIM;
               end else if (w_igual && (r_idx == '0)) begin
                  r_flags.eq  <= 1'b1;
                  r_state     <= ST_FIM;
               end else begin
                  r_idx       <= r_idx - 1'b1;
               end
            end
            ST_FIM: begin
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign o_busy = (r_state == ST_CMP) || (r_state == ST_FIM);
   assign o_done = (r_state == ST_FIM);
   assign o_gt   = r_flags.gt;
   assign o_lt   = r_flags.lt;
   assign o_eq   = r_flags.eq;
   assign o_err  = r_flags.err;

endmodule

// File: tb/tb_comparador_bcd_serial.sv
// Directed self-checking bench for comparador_bcd_serial with NDIG=4.
// Flags are compared as the nibble {gt, lt, eq, err}.
module tb_comparador_bcd_serial;

   localparam logic [3:0] F_NONE = 4'b0000;
   localparam logic [3:0] F_GT   = 4'b1000;
   localparam logic [3:0] F_LT   = 4'b0100;
   localparam logic [3:0] F_EQ   = 4'b0010;
   localparam logic [3:0] F_ERR  = 4'b0001;

   logic        i_clk;
   logic        i_rst;
   logic        i_start;
   logic [15:0] i_a;
   logic [15:0] i_b;
   logic        o_busy;
   logic        o_done;
   logic        o_gt;
   logic        o_lt;
   logic        o_eq;
   logic        o_err;

   int n_tests;
   int n_fail;

   comparador_bcd_serial #(.NDIG(4)) u_dut (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_start (i_start),
      .i_a     (i_a),
      .i_b     (i_b),
      .o_busy  (o_busy),
      .o_done  (o_done),
      .o_gt    (o_gt),
      .o_lt    (o_lt),
      .o_eq    (o_eq),
      .o_err   (o_err)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   function automatic logic [3:0] flags();
      return {o_gt, o_lt, o_eq, o_err};
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Launches one comparison and checks latency, busy span and result.
   // With disturb set, start is re-pulsed and a is changed mid-run.
   task automatic run_cmp(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic [3:0] exp_flags, input int exp_lat, input bit disturb);
      int  n;
      int  busy_n;
      bit  seen;
      @(negedge i_clk);
      i_a     = a;
      i_b     = b;
      i_start = 1'b1;
      @(posedge i_clk);
      @(negedge i_clk);
      i_start = 1'b0;
      n       = 1;
      busy_n  = 0;
      seen    = 1'b0;
      check({tag, "_busy_rise"}, 32'(o_busy), 32'd1);
      check({tag, "_flags_clr"}, 32'(flags()), 32'(F_NONE));
      while (!seen && n <= 20) begin
         if (o_busy) busy_n++;
         if (o_done) begin
            seen = 1'b1;
         end else begin
            if (disturb && n == 2) begin
               i_start = 1'b1;
               i_a     = 16'h9999;
            end
            @(negedge i_clk);
            i_start = 1'b0;
            n++;
         end
      end
      check({tag, "_done_lat"}, 32'(n), 32'(exp_lat));
      check({tag, "_busy_len"}, 32'(busy_n), 32'(exp_lat));
      check({tag, "_flags"}, 32'(flags()), 32'(exp_flags));
      @(negedge i_clk);
      check({tag, "_idle"}, 32'({o_busy, o_done}), 32'd0);
      check({tag, "_hold"}, 32'(flags()), 32'(exp_flags));
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      i_rst   = 1'b1;
      i_start = 1'b0;
      i_a     = '0;
      i_b     = '0;
      repeat (2) @(posedge i_clk);
      @(negedge i_clk);
      check("reset_state", 32'({o_busy, o_done, flags()}), 32'd0);
      i_rst = 1'b0;
      @(negedge i_clk);
      check("idle_no_start", 32'({o_busy, o_done, flags()}), 32'd0);

      run_cmp("eq_1234",   16'h1234, 16'h1234, F_EQ,  5, 1'b0);
      run_cmp("gt_9000",   16'h9000, 16'h1999, F_GT,  2, 1'b0);
      run_cmp("lt_0457",   16'h0457, 16'h0458, F_LT,  5, 1'b0);
      run_cmp("err_12A4",  16'h12A4, 16'h1200, F_ERR, 4, 1'b0);
      run_cmp("err_lsd",   16'h0009, 16'h000A, F_ERR, 5, 1'b0);
      run_cmp("lt_msd",    16'h0999, 16'h1000, F_LT,  2, 1'b0);
      run_cmp("disturb",   16'h1234, 16'h1234, F_EQ,  5, 1'b1);

      // start held high: FIM, one IDLE cycle, then a new run is accepted
      @(negedge i_clk);
      i_a     = 16'h9000;
      i_b     = 16'h1999;
      i_start = 1'b1;
      @(posedge i_clk);
      @(negedge i_clk);
      check("hold_c1_busy", 32'(o_busy), 32'd1);
      @(negedge i_clk);
      check("hold_c2_done", 32'({o_done, flags()}), 32'({1'b1, F_GT}));
      @(negedge i_clk);
      check("hold_c3_idle", 32'({o_busy, o_done}), 32'd0);
      i_b = 16'h9001;
      @(negedge i_clk);
      check("hold_c4_restart", 32'({o_busy, flags()}), 32'({1'b1, F_NONE}));
      i_start = 1'b0;
      repeat (4) @(negedge i_clk);
      check("hold_second_lt", 32'({o_done, flags()}), 32'({1'b1, F_LT}));
      @(negedge i_clk);

      // reset in the second CMP cycle, with a coincident start
      @(negedge i_clk);
      i_a     = 16'h1234;
      i_b     = 16'h1234;
      i_start = 1'b1;
      @(posedge i_clk);
      @(negedge i_clk);
      i_start = 1'b0;
      @(negedge i_clk);
      i_rst   = 1'b1;
      i_start = 1'b1;
      @(negedge i_clk);
      check("rst_mid_cmp", 32'({o_busy, o_done, flags()}), 32'd0);
      i_rst   = 1'b0;
      i_start = 1'b0;
      @(negedge i_clk);
      check("rst_start_ignored", 32'({o_busy, o_done, flags()}), 32'd0);

      run_cmp("post_rst_gt", 16'h0001, 16'h0000, F_GT, 5, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete, expected finish before 100000");
      $fatal(1);
   end

endmodule

// File: doc/comparador_bcd_serial.md
COMPARADOR_BCD_SERIAL -- requirements
Module: comparador_bcd_serial

Interface
REQ-001 Parameter NDIG, default 4: number of BCD digits per operand; legal range 1..8.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset is synchronous and active-high.
REQ-004 start  input  1  request a comparison; sampled only in IDLE.
REQ-005 a  input  4*NDIG  operand A, packed BCD, most significant digit in top nibble.
REQ-006 b  input  4*NDIG  operand B, same packing as a.
REQ-007 busy  output  1  high while a comparison is in progress.
REQ-008 done  output  1  one-cycle pulse marking valid result flags.
REQ-009 gt  output  1  A > B.
REQ-010 lt  output  1  A < B.
REQ-011 eq  output  1  A == B.
REQ-012 err  output  1  an examined digit of A or B exceeded 9.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, CMP, FIM.
REQ-014 IDLE with start=1 at an edge SHALL latch a and b into internal registers, set digit index to NDIG-1, clear gt/lt/eq/err, and enter CMP.
REQ-015 IDLE with start=0 SHALL hold state and all result flags.
REQ-016 CMP SHALL examine exactly one digit pair per cycle, the latched digits at the current index, most significant first.
REQ-017 In CMP, if either digit > 9, the block SHALL set err=1, leave gt/lt/eq at 0, and enter FIM.
REQ-018 In CMP, if both digits are valid and unequal, the block SHALL set gt or lt per the digit compare and enter FIM, skipping the remaining digits.
REQ-019 In CMP, if the digits are equal and the index is 0, the block SHALL set eq=1 and enter FIM.
REQ-020 In CMP, if the digits are equal and the index is > 0, the block SHALL decrement the index and remain in CMP.
REQ-021 FIM SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-022 busy SHALL be 1 in CMP and FIM, and 0 in IDLE.
REQ-023 Timing SHALL follow from the start edge:
- busy rises the next cycle.
- done is high k+1 cycles after the start edge, where k is the number of digits examined (1..NDIG).
REQ-024 gt/lt/eq/err SHALL be stable from the done cycle until the next accepted start.
REQ-025 Exactly one of gt/lt/eq/err SHALL be 1 whenever done=1.
REQ-026 start while busy=1 SHALL be ignored, and changes on a or b after acceptance SHALL have no effect.
REQ-027 start held high continuously SHALL begin a new comparison on the first IDLE cycle after FIM.

Reset
REQ-028 rst=1 at an edge SHALL force IDLE and clear busy, done, gt, lt, eq, err, the index and the operand registers, regardless of current state.
REQ-029 A start coincident with rst SHALL be ignored.
REQ-030 After rst falls, the first start SHALL be accepted normally.

Structure
REQ-031 A shared package SHALL hold:
- the state encoding (IDLE, CMP, FIM);
- the BCD digit width constant (4);
- the maximum valid digit constant (9).
REQ-032 Digit comparison SHALL be one combinational sub-module, comparador_digito_bcd, taking two 4-bit digits and producing maior, menor, igual and invalido.
REQ-033 That sub-module SHALL be instantiated exactly once and shared across all digit positions via the index multiplexer.

Verification (NDIG=4)
REQ-034 The bench SHALL cover these directed scenarios:
- a=0x1234, b=0x1234, start 1 cycle -> eq=1, done at cycle 5 after start, busy high 5 cycles.
- a=0x9000, b=0x1999 -> gt=1 after 1 digit, done at cycle 2.
- a=0x0457, b=0x0458 -> lt=1, done at cycle 5.
- a=0x12A4, b=0x1200 -> err=1 at index 1, done at cycle 4, gt=lt=eq=0.
- start pulsed again at cycle 2 of a comparison, and a changed mid-run -> ignored; original result unchanged.
- rst asserted in cycle 2 of CMP -> next cycle all outputs 0, state IDLE; following start 0x0001 vs 0x0000 -> gt=1.
